// File: rtl/life_pkg.sv
// Shared definitions for the Game-of-Life grid engine: FSM states, B3/S23 rule constants
// and cell-addressing helpers.
package life_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAW,
    ST_COUNT,
    ST_COMPUTE,
    ST_COMMIT
  } life_state_e;

  localparam int BIRTH      = 3;
  localparam int SURVIVE_LO = 2;
  localparam int SURVIVE_HI = 3;

  function automatic int cell_idx(input int y, input int x, input int max_x);
    return y * max_x + x;
  endfunction

  function automatic logic next_cell(input logic alive, input int n);
    if (alive) return (n >= SURVIVE_LO) && (n <= SURVIVE_HI);
    return n == BIRTH;
  endfunction

endpackage

// File: rtl/life_row_next.sv
// Combinational next-generation of one grid row from its upper, own and lower rows,
// plus the population of the produced row.
module life_row_next
  import life_pkg::*;
#(
  parameter int MAX_X = 32,
  parameter int WRAP  = 1,
  parameter int PW    = $clog2(MAX_X + 1)
) (
  input  logic [MAX_X-1:0] above_i,
  input  logic [MAX_X-1:0] cur_i,
  input  logic [MAX_X-1:0] below_i,
  output logic [MAX_X-1:0] next_o,
  output logic [PW-1:0]    pop_o
);

  int   xl;
  int   xr;
  int   n;
  int   cnt;
  logic hasL;
  logic hasR;

  // Horizontal neighbours either wrap around the row or read as dead past the edge.
  always_comb begin
    next_o = '0;
    xl     = 0;
    xr     = 0;
    n      = 0;
    cnt    = 0;
    hasL   = 1'b0;
    hasR   = 1'b0;
    for (int x = 0; x < MAX_X; x++) begin
      xl   = (x == 0) ? MAX_X - 1 : x - 1;
      xr   = (x == MAX_X - 1) ? 0 : x + 1;
      hasL = (x != 0) || (WRAP != 0);
      hasR = (x != MAX_X - 1) || (WRAP != 0);
      n    = int'(above_i[x]) + int'(below_i[x]);
      if (hasL) n = n + int'(above_i[xl]) + int'(cur_i[xl]) + int'(below_i[xl]);
      if (hasR) n = n + int'(above_i[xr]) + int'(cur_i[xr]) + int'(below_i[xr]);
      next_o[x] = next_cell(cur_i[x], n);
      if (next_o[x]) cnt = cnt + 1;
    end
    pop_o = PW'(cnt);
  end

endmodule

// File: rtl/life_grid_engine.sv
// Row-serial Conway (B3/S23) engine with pattern stamping and population count.
// Optional `LIFE_GEN_COUNT_EN adds a 16-bit generation counter output.
module life_grid_engine
  import life_pkg::*;
#(
  parameter int MAX_X = 32,
  parameter int MAX_Y = 24,
  parameter int WRAP  = 1,
  parameter int CNT_W = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   step,
  input  logic                   freeze,
  input  logic                   draw,
  input  logic [7:0]             cursor_x,
  input  logic [7:0]             cursor_y,
  input  logic [63:0]            pattern,
  output logic [MAX_X*MAX_Y-1:0] state,
  output logic [CNT_W-1:0]       alives,
  output logic                   busy,
  output logic                   done
`ifdef LIFE_GEN_COUNT_EN
  , output logic [15:0]          generation
`endif
);

  localparam int GN = MAX_X * MAX_Y;
  localparam int RW = $clog2(MAX_Y);
  localparam int PW = $clog2(MAX_X + 1);

  life_state_e      st_q, st_d;
  logic [RW-1:0]    row_q, row_d;
  logic [CNT_W-1:0] pop_q, pop_d;
  logic [CNT_W-1:0] alives_q, alives_d;
  logic [GN-1:0]    state_q, state_d;
  logic [GN-1:0]    shadow_q, shadow_d;
  logic             done_q, done_d;
  logic [7:0]       cx_q, cx_d;
  logic [7:0]       cy_q, cy_d;
  logic [63:0]      pat_q, pat_d;
`ifdef LIFE_GEN_COUNT_EN
  logic [15:0]      gen_q, gen_d;
`endif

  int               rowBase;
  logic             lastRow;
  logic [MAX_X-1:0] curRow, aboveRow, belowRow, nextRow;
  logic [PW-1:0]    curPop, nextPop;
  logic [GN-1:0]    stamp;
  int               tx, ty;

  assign rowBase = int'(row_q) * MAX_X;
  assign lastRow = (int'(row_q) == MAX_Y - 1);
  assign curPop  = PW'($countones(curRow));

  // Fetch the active row and its vertical neighbours; off-grid rows read as dead unless wrapping.
  always_comb begin
    curRow   = state_q[rowBase +: MAX_X];
    aboveRow = '0;
    belowRow = '0;
    if (row_q != '0) aboveRow = state_q[rowBase - MAX_X +: MAX_X];
    else if (WRAP != 0) aboveRow = state_q[GN - MAX_X +: MAX_X];
    if (!lastRow) belowRow = state_q[rowBase + MAX_X +: MAX_X];
    else if (WRAP != 0) belowRow = state_q[0 +: MAX_X];
  end

  life_row_next #(
    .MAX_X(MAX_X),
    .WRAP (WRAP),
    .PW   (PW)
  ) u_row_next (
    .above_i(aboveRow),
    .cur_i  (curRow),
    .below_i(belowRow),
    .next_o (nextRow),
    .pop_o  (nextPop)
  );

  // Stamp mask from the latched cursor/pattern; an origin outside the grid yields no cells.
  always_comb begin
    stamp = '0;
    tx    = 0;
    ty    = 0;
    if (int'(cx_q) < MAX_X && int'(cy_q) < MAX_Y) begin
      for (int r = 0; r < 8; r++) begin
        for (int c = 0; c < 8; c++) begin
          tx = int'(cx_q) + c;
          ty = int'(cy_q) + r;
          if (WRAP != 0) begin
            tx = tx % MAX_X;
            ty = ty % MAX_Y;
          end
          if (pat_q[r*8+c] && tx < MAX_X && ty < MAX_Y) stamp[cell_idx(ty, tx, MAX_X)] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    st_d     = st_q;
    row_d    = row_q;
    pop_d    = pop_q;
    alives_d = alives_q;
    state_d  = state_q;
    shadow_d = shadow_q;
    done_d   = 1'b0;
    cx_d     = cx_q;
    cy_d     = cy_q;
    pat_d    = pat_q;
`ifdef LIFE_GEN_COUNT_EN
    gen_d    = gen_q;
`endif
    unique case (st_q)
      ST_IDLE: begin
        // Draw has priority; a step presented alongside it is dropped.
        if (draw) begin
          st_d  = ST_DRAW;
          cx_d  = cursor_x;
          cy_d  = cursor_y;
          pat_d = pattern;
        end else if (step && !freeze) begin
          st_d  = ST_COMPUTE;
          row_d = '0;
          pop_d = '0;
        end
      end
      ST_DRAW: begin
        state_d = state_q | stamp;
        st_d    = ST_COUNT;
        row_d   = '0;
        pop_d   = '0;
      end
      ST_COUNT: begin
        pop_d = pop_q + CNT_W'(curPop);
        if (lastRow) begin
          alives_d = pop_q + CNT_W'(curPop);
          done_d   = 1'b1;
          row_d    = '0;
          st_d     = ST_IDLE;
        end else begin
          row_d = row_q + 1'b1;
        end
      end
      ST_COMPUTE: begin
        shadow_d[rowBase +: MAX_X] = nextRow;
        pop_d = pop_q + CNT_W'(nextPop);
        if (lastRow) begin
          row_d = '0;
          st_d  = ST_COMMIT;
        end else begin
          row_d = row_q + 1'b1;
        end
      end
      ST_COMMIT: begin
        state_d  = shadow_q;
        alives_d = pop_q;
        done_d   = 1'b1;
`ifdef LIFE_GEN_COUNT_EN
        gen_d    = gen_q + 16'd1;
`endif
        st_d     = ST_IDLE;
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q     <= ST_IDLE;
      row_q    <= '0;
      pop_q    <= '0;
      alives_q <= '0;
      state_q  <= '0;
      shadow_q <= '0;
      done_q   <= 1'b0;
      cx_q     <= '0;
      cy_q     <= '0;
      pat_q    <= '0;
`ifdef LIFE_GEN_COUNT_EN
      gen_q    <= '0;
`endif
    end else begin
      st_q     <= st_d;
      row_q    <= row_d;
      pop_q    <= pop_d;
      alives_q <= alives_d;
      state_q  <= state_d;
      shadow_q <= shadow_d;
      done_q   <= done_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      pat_q    <= pat_d;
`ifdef LIFE_GEN_COUNT_EN
      gen_q    <= gen_d;
`endif
    end
  end

  assign state  = state_q;
  assign alives = alives_q;
  assign busy   = (st_q != ST_IDLE);
  assign done   = done_q;
`ifdef LIFE_GEN_COUNT_EN
  assign generation = gen_q;
`endif

endmodule

// File: tb/tb_life_grid_engine.sv
// Scoreboard bench: a toroidal and a clipped-edge engine share stimulus; a cell-rule
// reference model predicts each committed grid, population and done timing.
module tb_life_grid_engine;

  localparam int MX = 32;
  localparam int MY = 24;
  localparam int GN = MX * MY;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          step = 1'b0;
  logic          freeze = 1'b0;
  logic          draw = 1'b0;
  logic [7:0]    cursor_x = '0;
  logic [7:0]    cursor_y = '0;
  logic [63:0]   pattern = '0;
  logic [GN-1:0] stW, stC;
  logic [11:0]   alW, alC;
  logic          busyW, busyC, doneW, doneC;
`ifdef LIFE_GEN_COUNT_EN
  logic [15:0]   genW, genC;
`endif

  life_grid_engine #(.MAX_X(MX), .MAX_Y(MY), .WRAP(1), .CNT_W(12)) dutW (
    .clk(clk), .rst(rst), .step(step), .freeze(freeze), .draw(draw),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .pattern(pattern),
    .state(stW), .alives(alW), .busy(busyW), .done(doneW)
`ifdef LIFE_GEN_COUNT_EN
    , .generation(genW)
`endif
  );

  life_grid_engine #(.MAX_X(MX), .MAX_Y(MY), .WRAP(0), .CNT_W(12)) dutC (
    .clk(clk), .rst(rst), .step(step), .freeze(freeze), .draw(draw),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .pattern(pattern),
    .state(stC), .alives(alC), .busy(busyC), .done(doneC)
`ifdef LIFE_GEN_COUNT_EN
    , .generation(genC)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [GN-1:0] grid;
    int            pop;
    int            due;
  } exp_t;

  exp_t          qW[$];
  exp_t          qC[$];
  logic [GN-1:0] gridW = '0;
  logic [GN-1:0] gridC = '0;
  int            total = 0;
  int            bad = 0;
  logic          pdW = 1'b0;
  logic          pdC = 1'b0;

  // Stamp an 8x8 pattern; origin outside the grid discards it, otherwise wrap or clip.
  function automatic logic [GN-1:0] modelStamp(input logic [GN-1:0] g, input int cx, input int cy,
                                               input logic [63:0] p, input bit wrap);
    logic [GN-1:0] res = g;
    int xx, yy;
    if (cx >= MX || cy >= MY) return res;
    for (int rr = 0; rr < 8; rr++)
      for (int cc = 0; cc < 8; cc++) begin
        if (!p[rr*8+cc]) continue;
        xx = cx + cc;
        yy = cy + rr;
        if (wrap) begin
          xx = xx % MX;
          yy = yy % MY;
        end else if (xx >= MX || yy >= MY) continue;
        res[yy*MX+xx] = 1'b1;
      end
    return res;
  endfunction

  // One B3/S23 generation computed cell by cell over the Moore neighbourhood.
  function automatic logic [GN-1:0] modelLife(input logic [GN-1:0] g, input bit wrap);
    logic [GN-1:0] nx = '0;
    int n, yy, xx;
    for (int y = 0; y < MY; y++)
      for (int x = 0; x < MX; x++) begin
        n = 0;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++) begin
            if (dy == 0 && dx == 0) continue;
            yy = y + dy;
            xx = x + dx;
            if (wrap) begin
              yy = (yy + MY) % MY;
              xx = (xx + MX) % MX;
            end else if (yy < 0 || yy >= MY || xx < 0 || xx >= MX) continue;
            n = n + int'(g[yy*MX+xx]);
          end
        nx[y*MX+x] = g[y*MX+x] ? (n == 2 || n == 3) : (n == 3);
      end
    return nx;
  endfunction

  task automatic checkVal(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  task automatic checkGrid(input string name, input logic [GN-1:0] act, input logic [GN-1:0] req);
    int first = -1;
    total++;
    if (act !== req) begin
      bad++;
      for (int i = GN - 1; i >= 0; i--) if (act[i] !== req[i]) first = i;
      $display("[TB] FAIL %s: grid pop got %0d, want %0d; first diff at y=%0d x=%0d",
               name, $countones(act), $countones(req), first / MX, first % MX);
    end
  endtask

  task automatic checkOutput(input bit wrap, input logic [GN-1:0] st, input int al,
                             input logic dn, input logic prevDn);
    exp_t  e;
    bit    empty;
    string tag = wrap ? "wrap" : "clip";
    if (!dn) return;
    checkVal({tag, "_done_width"}, int'(prevDn), 0);
    empty = wrap ? (qW.size() == 0) : (qC.size() == 0);
    if (empty) begin
      total++;
      bad++;
      $display("[TB] FAIL %s_unexpected_done: got done=1 at cycle %0d, want no done", tag, cyc);
      return;
    end
    if (wrap) e = qW.pop_front();
    else e = qC.pop_front();
    checkGrid({tag, "_state"}, st, e.grid);
    checkVal({tag, "_alives"}, al, e.pop);
    checkVal({tag, "_latency"}, cyc, e.due);
  endtask

  // Monitor: compares every done pulse against the oldest expectation.
  always @(negedge clk) begin
    if (rst) begin
      checkOutput(1'b1, stW, int'(alW), doneW, pdW);
      checkOutput(1'b0, stC, int'(alC), doneC, pdC);
    end
    pdW <= doneW;
    pdC <= doneC;
  end

  task automatic pushExp();
    exp_t e;
    e.due  = cyc + MY + 2;
    e.grid = gridW;
    e.pop  = $countones(gridW);
    qW.push_back(e);
    e.grid = gridC;
    e.pop  = $countones(gridC);
    qC.push_back(e);
  endtask

  // Issue one request while idle and record what the engines must produce.
  task automatic applyStimulus(input bit d, input bit s, input bit f, input int cx, input int cy,
                               input logic [63:0] p);
    @(posedge clk);
    #1;
    draw     = d;
    step     = s;
    freeze   = f;
    cursor_x = 8'(cx);
    cursor_y = 8'(cy);
    pattern  = p;
    if (d) begin
      gridW = modelStamp(gridW, cx, cy, p, 1'b1);
      gridC = modelStamp(gridC, cx, cy, p, 1'b0);
      pushExp();
    end else if (s && !f) begin
      gridW = modelLife(gridW, 1'b1);
      gridC = modelLife(gridC, 1'b0);
      pushExp();
    end
    @(posedge clk);
    #1;
    draw   = 1'b0;
    step   = 1'b0;
    freeze = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    while ((qW.size() != 0 || qC.size() != 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (qW.size() != 0 || qC.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL done_timeout: got %0d/%0d pending, want 0", qW.size(), qC.size());
      qW.delete();
      qC.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic doReset();
    rst   = 1'b0;
    gridW = '0;
    gridC = '0;
    qW.delete();
    qC.delete();
    #2;
    checkVal("rst_state_w", $countones(stW), 0);
    checkVal("rst_state_c", $countones(stC), 0);
    checkVal("rst_alives_w", int'(alW), 0);
    checkVal("rst_alives_c", int'(alC), 0);
    checkVal("rst_busy", int'(busyW) + int'(busyC), 0);
    checkVal("rst_done", int'(doneW) + int'(doneC), 0);
`ifdef LIFE_GEN_COUNT_EN
    checkVal("rst_generation", int'(genW) + int'(genC), 0);
`endif
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [GN-1:0] shifted;
    #3;
    doReset();

    $display("[TB] blinker");
    applyStimulus(1, 0, 0, 4, 5, 64'h7);
    waitIdle();
    applyStimulus(0, 1, 0, 0, 0, '0);
    waitIdle();
    checkVal("blinker_alives", int'(alW), 3);
    checkVal("blinker_vertical", int'(stW[4*MX+5]) + int'(stW[5*MX+5]) + int'(stW[6*MX+5]), 3);
    checkVal("blinker_old_cell", int'(stW[5*MX+4]), 0);
    applyStimulus(0, 1, 0, 0, 0, '0);
    waitIdle();

    $display("[TB] glider in corner");
    @(posedge clk); #1; doReset();
    applyStimulus(1, 0, 0, 29, 21, 64'h70402);
    waitIdle();
    for (int g = 0; g < 4; g++) begin
      applyStimulus(0, 1, 0, 0, 0, '0);
      waitIdle();
      checkVal("glider_wrap_pop", int'(alW), 5);
    end
    shifted = modelStamp('0, 30, 22, 64'h70402, 1'b1);
    checkGrid("glider_translated", stW, shifted);
    checkVal("clip_block_pop", int'(alC), 4);
    applyStimulus(0, 1, 0, 0, 0, '0);
    waitIdle();
    checkVal("clip_block_stable", int'(alC), 4);

    $display("[TB] request arbitration");
    applyStimulus(1, 1, 0, 10, 10, 64'h0000_0000_0007_0700);
    waitIdle();
    applyStimulus(0, 1, 0, 0, 0, '0);
    repeat (3) @(posedge clk);
    #1; draw = 1'b1; step = 1'b1; cursor_x = 8'd2; cursor_y = 8'd2; pattern = '1;
    @(posedge clk);
    #1; draw = 1'b0; step = 1'b0;
    @(posedge clk);
    #1; freeze = 1'b1;
    waitIdle();
    freeze = 1'b0;
    applyStimulus(0, 1, 1, 0, 0, '0);
    repeat (MY + 6) @(posedge clk);

    $display("[TB] stamp boundaries");
    applyStimulus(1, 0, 0, 32, 3, '1);
    waitIdle();
    applyStimulus(1, 0, 0, 3, 24, '1);
    waitIdle();
    applyStimulus(1, 0, 0, 28, 20, 64'h8142_2418_1824_4281);
    waitIdle();
    applyStimulus(0, 1, 0, 0, 0, '0);
    waitIdle();

    $display("[TB] random soup");
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1, ($urandom % 4) == 0, 0, int'($urandom_range(0, 35)),
                    int'($urandom_range(0, 27)),
                    {$urandom, $urandom} & {$urandom, $urandom});
      waitIdle();
      applyStimulus(0, 1, 0, 0, 0, '0);
      waitIdle();
    end

    $display("[TB] reset during compute");
    applyStimulus(0, 1, 0, 0, 0, '0);
    repeat (10) @(posedge clk);
    #1;
    checkVal("busy_mid_compute", int'(busyW) + int'(busyC), 2);
    doReset();
    repeat (MY + 6) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/life_grid_engine.md
LIFE_GRID_ENGINE -- requirements
Module: life_grid_engine

Interface
REQ-001 Parameter MAX_X, default 32, grid width in cells (4..64).
REQ-002 Parameter MAX_Y, default 24, grid height in cells (4..48).
REQ-003 Parameter WRAP, default 1: 1 = toroidal edges, 0 = cells outside grid are dead.
REQ-004 Parameter CNT_W, default 12, width of alives (SHALL satisfy 2^CNT_W > MAX_X*MAX_Y).
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 step  input  1  request one generation; sampled in IDLE only.
REQ-008 freeze  input  1  high blocks step acceptance.
REQ-009 draw  input  1  request stamping of pattern; sampled in IDLE only.
REQ-010 cursor_x  input  8  stamp column origin.
REQ-011 cursor_y  input  8  stamp row origin.
REQ-012 pattern  input  64  8x8 stamp; bit r*8+c maps to cell (cursor_y+r, cursor_x+c).
REQ-013 state  output  MAX_X*MAX_Y  committed grid; cell (y,x) at bit y*MAX_X+x.
REQ-014 alives  output  CNT_W  population of committed grid.
REQ-015 busy  output  1  high whenever FSM is not IDLE.
REQ-016 done  output  1  one-cycle pulse when a generation or draw commits.

Function
REQ-017 FSM states: IDLE, DRAW, COUNT, COMPUTE, COMMIT.
REQ-018 IDLE: draw=1 -> DRAW; else step=1 and freeze=0 -> COMPUTE; else stay.
REQ-019 Simultaneous draw and step in IDLE: draw SHALL win and step SHALL be dropped, not queued.
REQ-020 Requests arriving outside IDLE SHALL be ignored.
REQ-021 DRAW (1 cycle): state bits OR'ed with pattern; WRAP=1 wraps out-of-range targets modulo MAX_X/MAX_Y, WRAP=0 clips them; cursor_x>=MAX_X or cursor_y>=MAX_Y discards the stamp entirely; then COUNT.
REQ-022 COUNT: one row per cycle for MAX_Y cycles, accumulating row popcount; on last row alives updates, done pulses, -> IDLE.
REQ-023 COMPUTE: one row per cycle, rows 0..MAX_Y-1, next-state written to a shadow grid from unmodified state; rule B3/S23 (dead cell with exactly 3 live neighbours born; live cell with 2 or 3 survives; else dead).
REQ-024 Neighbours: 8-cell Moore neighbourhood; edge handling per WRAP.
REQ-025 COMPUTE accumulates shadow population; after row MAX_Y-1 -> COMMIT.
REQ-026 COMMIT (1 cycle): state <= shadow, alives <= accumulated count, done=1, -> IDLE.
REQ-027 Latency: step accepted at edge t; state valid at edge t+MAX_Y+1; draw latency MAX_Y+1 edges to done.
REQ-028 freeze rising while busy SHALL NOT abort the current generation.
REQ-029 Row counter SHALL never exceed MAX_Y-1; population accumulator SHALL not overflow (per REQ-004).

Reset
REQ-030 While rst=0: state, shadow, alives, row counter = 0; busy=0, done=0; FSM = IDLE.
REQ-031 Reset asserted mid-COMPUTE/COUNT SHALL discard partial results; no done pulse.

Configuration
REQ-032 Macro LIFE_GEN_COUNT_EN: when defined, adds output generation (16 bits), reset 0, incremented at each COMMIT, wrapping 0xFFFF->0, unaffected by DRAW.
REQ-033 Without LIFE_GEN_COUNT_EN the port and counter SHALL be absent; all other behaviour identical.

Structure
REQ-034 Shared package life_pkg holds FSM state enum, rule constants (BIRTH=3, SURVIVE_LO=2, SURVIVE_HI=3) and the cell-index function y*MAX_X+x.
REQ-035 One sub-module life_row_next: combinational, takes three rows (above, current, below) plus WRAP, returns next row and its popcount; instantiated once.

Verification
REQ-036 Blinker cells (5,4),(5,5),(5,6), step -> after MAX_Y+1 cycles cells (4,5),(5,5),(6,5), alives=3, done one cycle.
REQ-037 WRAP=1 glider near (22,30), 4 steps -> glider translated (+1,+1) modulo grid, alives=5 each generation.
REQ-038 WRAP=0 same glider at corner -> collapses to 2x2 block, alives=4, stable afterwards.
REQ-039 draw pulse while busy=1 -> state unchanged; draw and step same IDLE cycle -> stamp applied, no generation.
REQ-040 rst=0 at COMPUTE row 10 -> state=0, alives=0, busy=0, no done; generation=0 with LIFE_GEN_COUNT_EN.
